// File: rtl/traceback_sequencer.sv
// Traceback-phase sequencer for the Needleman-Wunsch core: RAM read, trace enable, pair emit, step.
// Optional length watchdog is enabled by defining TRACEBACK_WATCHDOG_EN; otherwise err is tied low.
module traceback_sequencer #(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1),
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               end_c,
  input  logic [2:0]         datoA,
  input  logic [2:0]         datoB,
  output logic               ram_rd_en,
  output logic               en_traceB,
  output logic               step_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_a,
  output logic [2:0]         out_b,
  output logic               busy,
  output logic               done,
  output logic [BitAddr+1:0] align_len,
  output logic               err
);

  localparam int              LenW     = BitAddr + 2;
  localparam logic [LenW-1:0] MaxLen   = LenW'(2 * N);
  localparam logic [2:0]      WaitLoad = 3'(RD_LAT);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_READ = 4'd1,
    S_WAIT = 4'd2,
    S_EXEC = 4'd3,
    S_CAP  = 4'd4,
    S_EMIT = 4'd5,
    S_ADV  = 4'd6,
    S_CHK  = 4'd7,
    S_FIN  = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      wait_q, wait_d;
  logic [2:0]      out_a_q, out_a_d;
  logic [2:0]      out_b_q, out_b_d;
  logic [LenW-1:0] len_q, len_d;
  logic            accept_s;
  logic            handshake_s;
  logic            wd_hit_s;

  assign accept_s    = (state_q == S_IDLE) && start;
  assign handshake_s = (state_q == S_EMIT) && out_ready;

`ifdef TRACEBACK_WATCHDOG_EN
  logic err_q, err_d;

  assign wd_hit_s = (state_q == S_CHK) && !end_c && (len_q == MaxLen);

  // Sticky watchdog flag: cleared only by reset or an accepted start.
  always_comb begin
    err_d = err_q;
    if (accept_s) begin
      err_d = 1'b0;
    end else if (wd_hit_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wd_hit_s = 1'b0;
  assign err      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; end_c matters only on an accepted start and in CHK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = end_c ? S_FIN : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        if (wait_q == 3'd1) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_EXEC: state_d = S_CAP;
      S_CAP:  state_d = S_EMIT;
      S_EMIT: begin
        if (out_ready) begin
          state_d = S_ADV;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_ADV:  state_d = S_CHK;
      S_CHK: begin
        if (end_c || wd_hit_s) begin
          state_d = S_FIN;
        end else begin
          state_d = S_READ;
        end
      end
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: wait counter, captured pair, saturating length.
  always_comb begin
    wait_d  = wait_q;
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    len_d   = len_q;

    if (state_q == S_READ) begin
      wait_d = WaitLoad;
    end else if (state_q == S_WAIT) begin
      wait_d = wait_q - 3'd1;
    end else begin
      wait_d = wait_q;
    end

    if (state_q == S_CAP) begin
      out_a_d = datoA;
      out_b_d = datoB;
    end else begin
      out_a_d = out_a_q;
      out_b_d = out_b_q;
    end

    if (accept_s) begin
      len_d = {LenW{1'b0}};
    end else if (handshake_s && (len_q != MaxLen)) begin
      len_d = len_q + LenW'(1);
    end else begin
      len_d = len_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= 3'd0;
      out_a_q <= 3'd0;
      out_b_q <= 3'd0;
      len_q   <= {LenW{1'b0}};
    end else begin
      wait_q  <= wait_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      len_q   <= len_d;
    end
  end

  // Control outputs decoded purely from the state register.
  always_comb begin
    ram_rd_en = 1'b0;
    en_traceB = 1'b0;
    step_en   = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE:  busy      = 1'b0;
      S_READ:  ram_rd_en = 1'b1;
      S_WAIT:  busy      = 1'b1;
      S_EXEC:  en_traceB = 1'b1;
      S_CAP:   busy      = 1'b1;
      S_EMIT:  out_valid = 1'b1;
      S_ADV:   step_en   = 1'b1;
      S_CHK:   busy      = 1'b1;
      S_FIN:   done      = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign align_len = len_q;

endmodule
